// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register offsets,
// CTRL bit positions and the decoded window size.
package mmio_timer_pkg;

  localparam int unsigned WIN_W  = 5;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [IDX_W-1:0] OFF_CTRL     = 3'd0;
  localparam logic [IDX_W-1:0] OFF_PRESCALE = 3'd1;
  localparam logic [IDX_W-1:0] OFF_LOAD     = 3'd2;
  localparam logic [IDX_W-1:0] OFF_STATUS   = 3'd3;
  localparam logic [IDX_W-1:0] OFF_COUNT    = 3'd4;

  localparam int unsigned CTRL_W      = 3;
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by PRESCALE+1 while enabled; holds its phase when disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  // Clear wins so a reprogrammed period always starts from a fresh phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Bus-responder timer: register file, address decode, combinational read mux
// and the COUNT/EXPIRED update logic around a shared prescaler.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              sel_hit,
  output logic              irq
);

  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_W-1:0]     load;
  logic [DATA_W-1:0]     count;
  logic                  expired;

  logic [IDX_W-1:0] reg_idx;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_prescale;
  logic             wr_load;
  logic             clr_status;
  logic             tick;
  logic             expire;
  logic             unused_adr;

  assign sel_hit     = (dataadr[DATA_W-1:WIN_W] == BASE_ADDR[DATA_W-1:WIN_W]);
  assign reg_idx     = dataadr[WIN_W-1:2];
  assign unused_adr  = ^dataadr[1:0];
  assign wr          = memwrite && sel_hit;
  assign wr_ctrl     = wr && (reg_idx == OFF_CTRL);
  assign wr_prescale = wr && (reg_idx == OFF_PRESCALE);
  assign wr_load     = wr && (reg_idx == OFF_LOAD);
  assign clr_status  = wr && (reg_idx == OFF_STATUS) && writedata[0];
  assign expire      = tick && (count == DATA_W'(1));

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl[CTRL_EN]),
    .prescale (prescale),
    .clear    (wr_prescale || wr_load),
    .tick     (tick)
  );

  // Configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      prescale <= '0;
      load     <= '0;
    end else begin
      if (wr_ctrl)     ctrl     <= writedata[CTRL_W-1:0];
      if (wr_prescale) prescale <= writedata[PRESCALE_W-1:0];
      if (wr_load)     load     <= writedata;
    end
  end

  // COUNT: a LOAD write overrides any tick update in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_load) begin
      count <= writedata;
    end else if (tick) begin
      if (count > DATA_W'(1)) begin
        count <= count - DATA_W'(1);
      end else if (expire) begin
        count <= ctrl[CTRL_AUTO] ? load : '0;
      end
    end
  end

  // EXPIRED: a new expiry beats a same-cycle clear so the event is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (clr_status) begin
      expired <= 1'b0;
    end
  end

  assign irq = expired && ctrl[CTRL_IRQ_EN];

  always_comb begin
    readdata = '0;
    if (sel_hit) begin
      case (reg_idx)
        OFF_CTRL:     readdata = DATA_W'(ctrl);
        OFF_PRESCALE: readdata = DATA_W'(prescale);
        OFF_LOAD:     readdata = load;
        OFF_STATUS:   readdata = DATA_W'(expired);
        OFF_COUNT:    readdata = count;
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed and randomized bench for mmio_timer against a cycle-level
// behavioural model of the register map and timer rules.
module tb_mmio_timer;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel_hit;
  logic        irq;

  int checks;
  int errors;

  // Reference state of the timer as seen by software.
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [15:0] m_phase;
  logic [31:0] m_load;
  logic [31:0] m_count;
  logic        m_exp;

  mmio_timer #(
    .BASE_ADDR  (B),
    .PRESCALE_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .sel_hit   (sel_hit),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_pre = '0; m_phase = '0; m_load = '0; m_count = '0; m_exp = 1'b0;
  endtask

  function automatic logic m_hit(input logic [31:0] adr);
    return adr[31:5] == B[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] adr);
    if (!m_hit(adr)) return 32'd0;
    case (adr[4:2])
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return {16'd0, m_pre};
      3'd2:    return m_load;
      3'd3:    return {31'd0, m_exp};
      3'd4:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the timer: a tick is every (PRESCALE+1)-th enabled cycle.
  task automatic m_step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    logic        w;
    logic [2:0]  idx;
    logic        tick;
    logic [31:0] nc;
    logic        nx;
    logic [15:0] np;
    w    = we && m_hit(adr);
    idx  = adr[4:2];
    tick = m_ctrl[0] && (m_phase == m_pre);
    nc   = m_count;
    nx   = m_exp;
    np   = m_phase;
    if (m_ctrl[0]) np = tick ? 16'd0 : m_phase + 16'd1;
    if (w && idx == 3'd3 && wd[0]) nx = 1'b0;
    if (tick && m_count > 1) nc = m_count - 1;
    if (tick && m_count == 1) begin
      nx = 1'b1;
      nc = m_ctrl[1] ? m_load : 32'd0;
    end
    if (w) begin
      case (idx)
        3'd0: m_ctrl = wd[2:0];
        3'd1: begin m_pre = wd[15:0]; np = 16'd0; end
        3'd2: begin m_load = wd; nc = wd; np = 16'd0; end
        default: ;
      endcase
    end
    m_count = nc;
    m_exp   = nx;
    m_phase = np;
  endtask

  task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    memwrite  = we;
    dataadr   = adr;
    writedata = wd;
    @(posedge clk);
    m_step(we, adr, wd);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic peek(input logic [31:0] adr, output logic [31:0] val);
    memwrite = 1'b0;
    dataadr  = adr;
    #1;
    val = readdata;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    peek(B + 32'h10, v);
    check({tag, " count"}, v, m_count);
    peek(B + 32'h0C, v);
    check({tag, " status"}, v, {31'd0, m_exp});
    check({tag, " irq"}, {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] r;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_cnt;
    logic        exp_x;
    int          off;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    memwrite  = 1'b0;
    dataadr   = B;
    writedata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state of every offset, plus an out-of-window address.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, B + 32'(i * 4), 32'd0);
      check("reset rd", readdata, 32'd0);
      check("reset hit", {31'd0, sel_hit}, 32'd1);
    end
    check("reset irq", {31'd0, irq}, 32'd0);
    peek(32'h1234_5678, v);
    check("miss rd", v, 32'd0);
    check("miss hit", {31'd0, sel_hit}, 32'd0);

    // One-shot: PRESCALE=0, LOAD=3, CTRL=EN|IRQ_EN.
    cycle(1'b1, B + 32'h04, 32'd0);
    cycle(1'b1, B + 32'h08, 32'd3);
    cycle(1'b1, B + 32'h00, 32'd5);
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, B + 32'h10, 32'd0);
      check("oneshot count", readdata, (i < 3) ? 32'(3 - i) : 32'd0);
      check("oneshot irq", {31'd0, irq}, (i >= 3) ? 32'd1 : 32'd0);
      check_state("oneshot");
    end

    // Auto-reload: PRESCALE=2, LOAD=2, CTRL=EN|AUTO; expiry every 6 clocks.
    cycle(1'b1, B + 32'h00, 32'd0);
    cycle(1'b1, B + 32'h0C, 32'd1);
    cycle(1'b1, B + 32'h04, 32'd2);
    cycle(1'b1, B + 32'h08, 32'd2);
    cycle(1'b1, B + 32'h00, 32'd3);
    for (int j = 1; j <= 24; j++) begin
      if (j == 7 || j == 13 || j == 18) cycle(1'b1, B + 32'h0C, 32'd1);
      else if (j == 21)                 cycle(1'b1, B + 32'h08, 32'd10);
      else                              cycle(1'b0, B + 32'h10, 32'd0);
      if (j <= 20)      exp_cnt = ((j / 3) % 2 == 0) ? 32'd2 : 32'd1;
      else if (j < 24)  exp_cnt = 32'd10;
      else              exp_cnt = 32'd9;
      exp_x = (j == 6) || (j == 12) || (j >= 18);
      peek(B + 32'h10, v);
      check("auto count", v, exp_cnt);
      peek(B + 32'h0C, v);
      check("auto status", v, {31'd0, exp_x});
      check_state("auto");
    end

    // Async reset mid-count with irq high and no clock edge.
    cycle(1'b1, B + 32'h00, 32'd7);
    check("pre-reset irq", {31'd0, irq}, 32'd1);
    #1;
    reset = 1'b0;
    m_reset();
    #1;
    check("async irq", {31'd0, irq}, 32'd0);
    peek(B + 32'h00, v);
    check("async ctrl", v, 32'd0);
    peek(B + 32'h10, v);
    check("async count", v, 32'd0);
    peek(B + 32'h0C, v);
    check("async status", v, 32'd0);
    @(negedge clk);
    peek(B + 32'h08, v);
    check("async load", v, 32'd0);
    peek(B + 32'h04, v);
    check("async prescale", v, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, B + 32'h10, 32'd0);
      check("idle after reset", readdata, 32'd0);
    end
    cycle(1'b1, B + 32'h08, 32'd2);
    cycle(1'b1, B + 32'h00, 32'd1);
    cycle(1'b0, B + 32'h10, 32'd0);
    check("resume count", readdata, 32'd1);
    check_state("resume");

    // Randomized register traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r   = $urandom;
      off = $urandom_range(0, 7);
      adr = ((r % 17) == 0) ? 32'h0000_1000 : B;
      adr = adr + 32'(off * 4) + 32'($urandom_range(0, 3));
      case (off)
        1:       wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        2:       wd = 32'($urandom_range(0, 6));
        default: wd = $urandom;
      endcase
      cycle((r % 4) == 0, adr, wd);
      check("rand rd", readdata, m_read(adr));
      check("rand hit", {31'd0, sel_hit}, {31'd0, m_hit(adr)});
      check("rand irq", {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
      peek(B + 32'h10, v);
      check("rand count", v, m_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counting timer that sits on the processor's data-memory bus as a responder alongside the data memory. It decodes `dataadr`, accepts single-cycle stores on `memwrite`, and returns load data combinationally on `readdata` so a single-cycle `lw` completes in the same clock. The top level muxes `readdata` between this block and the data memory using `sel_hit`, and routes `irq` to a status or interrupt input.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: base of the 32-byte register window; only bits [31:5] are compared.
- `PRESCALE_W`, 16: width of the PRESCALE register and the prescaler counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memwrite` in 1: store strobe from the CPU.
- `dataadr` in 32: byte address from the CPU; [4:2] selects the register, [1:0] ignored.
- `writedata` in 32: store data.
- `readdata` out 32: load data, combinational.
- `sel_hit` out 1: combinational; high when `dataadr[31:5] == BASE_ADDR[31:5]`.
- `irq` out 1: `EXPIRED & IRQ_EN`, derived from flops only.

## Operation
- Register map (offset from base):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits write-ignored and read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 LOAD: 32-bit reload value.
  - 0x0C STATUS: bit0 EXPIRED, sticky; writing 1 clears it, writing 0 has no effect.
  - 0x10 COUNT: read-only; writes are ignored.
  - 0x14–0x1C: read 0; writes are ignored.
- Write side effects:
  - A write to LOAD also sets COUNT to the new value and clears the prescaler.
  - A write to PRESCALE clears the prescaler.
- Reads:
  - `readdata` shows the selected register when `sel_hit` is high, and 0 otherwise.
  - Reads have no side effects.
- Prescaler (`pcnt`): while EN=1, `tick` = (`pcnt` == PRESCALE). On tick `pcnt` goes to 0; otherwise it increments. While EN=0, `pcnt` holds and no ticks occur.
- On each tick:
  - COUNT > 1: COUNT decrements by 1.
  - COUNT == 1: EXPIRED is set; COUNT reloads to LOAD if AUTO_RELOAD=1, otherwise goes to 0.
  - COUNT == 0: nothing happens; the timer is stopped.
  - With LOAD=0 and AUTO_RELOAD=1, the timer never expires.
- Simultaneous events:
  - A CPU write to LOAD beats a tick update of COUNT in the same cycle.
  - An EXPIRED set beats a write-1-to-clear in the same cycle, so the event is not lost.
  - A CTRL write that clears EN in a tick cycle still lets that tick complete.
- Width rules: COUNT is 32-bit unsigned and never wraps below 0. `pcnt` compares in PRESCALE_W bits.

## Timing
- Reset (async assert, any time including mid-count):
  - CTRL, PRESCALE, LOAD, COUNT, EXPIRED and `pcnt` all go to 0.
  - `irq` drops to 0 immediately, without waiting for `clk`.
  - `readdata` and `sel_hit` follow `dataadr` combinationally and are 0 for out-of-window addresses.
- Writes take effect at the rising edge where `memwrite` and `sel_hit` are both high.
- Reads in the same cycle return the value from before that edge.
- With EN written to 1 at edge k and PRESCALE=P, ticks occur at edges k+P+1, k+2(P+1), and so on.
- With PRESCALE=0, LOAD=3 and EN set at edge k:
  - COUNT reads 2, 1, 0 after edges k+1, k+2, k+3.
  - EXPIRED and `irq` (if IRQ_EN) go high after edge k+3.
- Auto-reload period is LOAD×(PRESCALE+1) clocks between successive EXPIRED sets.

## Structure
- Package `mmio_timer_pkg`:
  - Register offset constants.
  - CTRL bit indices.
  - The window address width (5).
- Sub-module `timer_prescaler`:
  - Inputs: clk, reset, EN, PRESCALE, clear.
  - Output: `tick`.
- Register file, address decode, read mux and COUNT logic live in `mmio_timer`.

## Test plan
- Reset, then read every offset. Required: all read 0, `irq`=0; an address outside the window gives `sel_hit`=0 and `readdata`=0.
- PRESCALE=0, LOAD=3, CTRL=0x5. Required: COUNT reads 2, 1, 0 on consecutive cycles; EXPIRED=1 and `irq`=1 on the third; COUNT stays 0 afterwards.
- PRESCALE=2, LOAD=2, CTRL=0x3. Required: EXPIRED is set every 6 clocks; COUNT cycles 2→1→2 on each reload; write STATUS=1 clears EXPIRED.
- Issue a STATUS write-1-to-clear in the same cycle as an expiry. Required: EXPIRED stays 1. Then write LOAD=10 in a tick cycle. Required: COUNT reads 10 after that edge.
- Assert `reset` low mid-count with `irq`=1 and no clock edge. Required: `irq` and all registers go to 0 at once; counting resumes only after registers are rewritten.
